envelope_coeff_ctrl: RTL and testbench

//  Coefficient scheduler for the magnitude-approximation datapath in the envelope block. It stages

---
 rtl/envelope_coeff_ctrl.sv | 171 +++++++++++++++++
 tb/tb_envelope_coeff_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/envelope_coeff_ctrl.sv
// Coefficient scheduler for the envelope magnitude datapath: stages alpha/beta num/denom writes
// and swaps them in atomically at a packet boundary once the datapath pipeline has drained.
module envelope_coeff_ctrl #(
    parameter int unsigned SR_ALPHA_NUM    = 192,
    parameter int unsigned SR_BETA_NUM     = 193,
    parameter int unsigned SR_ALPHA_DENOM  = 194,
    parameter int unsigned SR_BETA_DENOM   = 195,
    parameter int unsigned SR_COMMIT       = 196,
    parameter int unsigned COEF_W          = 16,
    parameter int unsigned CNT_W           = 8,
    parameter int unsigned DEF_ALPHA_NUM   = 61,
    parameter int unsigned DEF_ALPHA_DENOM = 64,
    parameter int unsigned DEF_BETA_NUM    = 13,
    parameter int unsigned DEF_BETA_DENOM  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              set_stb,
    input  logic [7:0]        set_addr,
    input  logic [31:0]       set_data,
    input  logic              s_tvalid,
    input  logic              s_tlast,
    output logic              s_tready,
    output logic              m_tvalid,
    input  logic              m_tready,
    input  logic              d_tvalid,
    input  logic              d_tready,
    output logic [COEF_W-1:0] alpha_num,
    output logic [COEF_W-1:0] alpha_denom,
    output logic [COEF_W-1:0] beta_num,
    output logic [COEF_W-1:0] beta_denom,
    output logic              coeff_update,
    output logic              busy,
    output logic              err_zero_denom,
    output logic [63:0]       rb_coeffs
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_DRAIN,
        ST_APPLY
    } state_t;

    localparam logic [CNT_W-1:0] OUT_MAX = '1;

    state_t             state;
    logic               commit_pend;
    logic               in_packet;
    logic [CNT_W-1:0]   outstanding;

    logic [COEF_W-1:0]  sh_alpha_num;
    logic [COEF_W-1:0]  sh_alpha_denom;
    logic [COEF_W-1:0]  sh_beta_num;
    logic [COEF_W-1:0]  sh_beta_denom;

    logic               wr_alpha_num;
    logic               wr_alpha_denom;
    logic               wr_beta_num;
    logic               wr_beta_denom;
    logic               wr_commit;
    logic [COEF_W-1:0]  coef_in;
    logic               shadow_zero;
    logic               hold;
    logic               accept;
    logic               out_beat;
    logic               unused_set_data;

    // Settings bus decode
    assign wr_alpha_num   = set_stb && (set_addr == 8'(SR_ALPHA_NUM));
    assign wr_beta_num    = set_stb && (set_addr == 8'(SR_BETA_NUM));
    assign wr_alpha_denom = set_stb && (set_addr == 8'(SR_ALPHA_DENOM));
    assign wr_beta_denom  = set_stb && (set_addr == 8'(SR_BETA_DENOM));
    assign wr_commit      = set_stb && (set_addr == 8'(SR_COMMIT));
    assign coef_in        = set_data[COEF_W-1:0];
    assign unused_set_data = ^set_data[31:COEF_W];

    assign shadow_zero = (sh_alpha_denom == '0) || (sh_beta_denom == '0);

    // Stream gating: stall while draining/swapping or when the in-flight counter is full
    assign hold     = (state == ST_DRAIN) || (state == ST_APPLY) || (outstanding == OUT_MAX);
    assign m_tvalid = s_tvalid && !hold;
    assign s_tready = m_tready && !hold;
    assign accept   = s_tvalid && s_tready;
    assign out_beat = d_tvalid && d_tready && (outstanding != '0);

    assign busy      = (state != ST_IDLE) || commit_pend;
    assign rb_coeffs = {16'(alpha_num), 16'(alpha_denom), 16'(beta_num), 16'(beta_denom)};

    // Shadow coefficient registers, writable in every state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_alpha_num   <= COEF_W'(DEF_ALPHA_NUM);
            sh_alpha_denom <= COEF_W'(DEF_ALPHA_DENOM);
            sh_beta_num    <= COEF_W'(DEF_BETA_NUM);
            sh_beta_denom  <= COEF_W'(DEF_BETA_DENOM);
        end else begin
            if (wr_alpha_num)   sh_alpha_num   <= coef_in;
            if (wr_alpha_denom) sh_alpha_denom <= coef_in;
            if (wr_beta_num)    sh_beta_num    <= coef_in;
            if (wr_beta_denom)  sh_beta_denom  <= coef_in;
        end
    end

    // Packet boundary tracking and in-flight beat count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_packet   <= 1'b0;
            outstanding <= '0;
        end else begin
            if (accept) in_packet <= !s_tlast;
            if (accept && !out_beat) begin
                outstanding <= outstanding + CNT_W'(1);
            end else if (!accept && out_beat) begin
                outstanding <= outstanding - CNT_W'(1);
            end
        end
    end

    // Commit sequencing and active coefficient swap
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            commit_pend    <= 1'b0;
            err_zero_denom <= 1'b0;
            coeff_update   <= 1'b0;
            alpha_num      <= COEF_W'(DEF_ALPHA_NUM);
            alpha_denom    <= COEF_W'(DEF_ALPHA_DENOM);
            beta_num       <= COEF_W'(DEF_BETA_NUM);
            beta_denom     <= COEF_W'(DEF_BETA_DENOM);
        end else begin
            coeff_update <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (wr_commit) begin
                        if (shadow_zero) err_zero_denom <= 1'b1;
                        else             state          <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (!in_packet) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (wr_commit)          commit_pend <= 1'b1;
                    if (outstanding == '0)  state       <= ST_APPLY;
                end
                ST_APPLY: begin
                    alpha_num    <= sh_alpha_num;
                    alpha_denom  <= sh_alpha_denom;
                    beta_num     <= sh_beta_num;
                    beta_denom   <= sh_beta_denom;
                    coeff_update <= 1'b1;
                    commit_pend  <= 1'b0;
                    // A commit queued during the drain is validated only now
                    if (commit_pend || wr_commit) begin
                        if (shadow_zero) begin
                            err_zero_denom <= 1'b1;
                            state          <= ST_IDLE;
                        end else begin
                            state <= ST_ARMED;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_envelope_coeff_ctrl.sv
// Bench for envelope_coeff_ctrl: directed scenarios plus random traffic, every cycle compared
// against a behavioural model of the commit/boundary/drain/swap rules.
module tb_envelope_coeff_ctrl;

    localparam int LAT = 3;
    localparam int P_IDLE  = 0;
    localparam int P_ARMED = 1;
    localparam int P_DRAIN = 2;
    localparam int P_APPLY = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic        s_tvalid, s_tlast, s_tready;
    logic        m_tvalid, m_tready;
    logic        d_tvalid, d_tready;
    logic [15:0] alpha_num, alpha_denom, beta_num, beta_denom;
    logic        coeff_update, busy, err_zero_denom;
    logic [63:0] rb_coeffs;

    envelope_coeff_ctrl dut (
        .clk(clk), .reset(reset),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tvalid(m_tvalid), .m_tready(m_tready),
        .d_tvalid(d_tvalid), .d_tready(d_tready),
        .alpha_num(alpha_num), .alpha_denom(alpha_denom),
        .beta_num(beta_num), .beta_denom(beta_denom),
        .coeff_update(coeff_update), .busy(busy),
        .err_zero_denom(err_zero_denom), .rb_coeffs(rb_coeffs)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int upd_cnt  = 0;
    bit last_acc = 1'b0;
    bit spur     = 1'b0;
    int pipe_q[$];

    // Reference model state
    int          phase;
    bit          pend, merr, in_pkt;
    int          outst;
    logic [15:0] sh[4];
    logic [15:0] act[4];
    bit          mupd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        phase = P_IDLE; pend = 0; merr = 0; in_pkt = 0; outst = 0; mupd = 0;
        sh[0] = 16'd61; sh[1] = 16'd64; sh[2] = 16'd13; sh[3] = 16'd32;
        act = sh;
        pipe_q.delete();
    endtask

    task automatic idle_inputs();
        set_stb = 0; set_addr = 8'd0; set_data = 32'd0;
        s_tvalid = 0; s_tlast = 0; m_tready = 1; d_tready = 1; d_tvalid = 0; spur = 0;
    endtask

    function automatic int addr_idx(input logic [7:0] a);
        case (a)
            8'd192:  return 0;
            8'd194:  return 1;
            8'd193:  return 2;
            8'd195:  return 3;
            default: return -1;
        endcase
    endfunction

    // One clock: check gating, advance model from the spec rules, check registered outputs
    task automatic cycle();
        bit hold, acc, dec, commit, zero;
        int nphase, idx;
        hold = (phase == P_DRAIN) || (phase == P_APPLY) || (outst == 255);
        d_tvalid = spur || (pipe_q.size() > 0 && pipe_q[0] <= cyc);
        #1;
        chk("m_tvalid", 64'(m_tvalid), 64'(s_tvalid && !hold));
        chk("s_tready", 64'(s_tready), 64'(m_tready && !hold));
        acc = s_tvalid && m_tready && !hold;
        dec = d_tvalid && d_tready && (outst > 0);
        if (!spur && d_tvalid && d_tready) void'(pipe_q.pop_front());
        if (acc) pipe_q.push_back(cyc + LAT);
        last_acc = acc;

        commit = set_stb && (set_addr == 8'd196);
        zero   = (sh[1] == 16'd0) || (sh[3] == 16'd0);
        nphase = phase;
        mupd   = 0;
        if (phase == P_IDLE) begin
            if (commit) begin
                if (zero) merr = 1;
                else      nphase = P_ARMED;
            end
        end else if (phase == P_ARMED) begin
            if (!in_pkt) nphase = P_DRAIN;
        end else if (phase == P_DRAIN) begin
            if (commit) pend = 1;
            if (outst == 0) nphase = P_APPLY;
        end else begin
            act  = sh;
            mupd = 1;
            if (pend || commit) nphase = zero ? P_IDLE : P_ARMED;
            else                nphase = P_IDLE;
            if ((pend || commit) && zero) merr = 1;
            pend = 0;
        end
        phase = nphase;
        if (acc) in_pkt = !s_tlast;
        outst = outst + int'(acc) - int'(dec);
        idx = addr_idx(set_addr);
        if (set_stb && idx >= 0) sh[idx] = set_data[15:0];

        @(posedge clk);
        cyc++;
        #1;
        if (coeff_update === 1'b1) upd_cnt++;
        chk("rb_coeffs", rb_coeffs, {act[0], act[1], act[2], act[3]});
        chk("coeff_update", 64'(coeff_update), 64'(mupd));
        chk("busy", 64'(busy), 64'((phase != P_IDLE) || pend));
        chk("err_zero_denom", 64'(err_zero_denom), 64'(merr));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        set_stb = 1; set_addr = a; set_data = d;
        cycle();
        set_stb = 0; set_addr = 8'd0; set_data = 32'd0;
    endtask

    task automatic commit_req();
        wr(8'd196, 32'hFFFF_FFFF);
    endtask

    task automatic send_pkt(input int len, input int commit_at, input bit rnd_valid);
        int n = 0;
        int guard = 0;
        bit did = 0;
        while (n < len && guard < 1000) begin
            s_tvalid = rnd_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_tlast  = (n == len - 1);
            if (n == commit_at && !did) begin
                set_stb = 1; set_addr = 8'd196; set_data = 32'd0; did = 1;
            end
            cycle();
            set_stb = 0; set_addr = 8'd0;
            if (last_acc) n++;
            guard++;
        end
        s_tvalid = 0; s_tlast = 0;
        if (n != len) chk("send_timeout", 64'(n), 64'(len));
    endtask

    task automatic do_reset();
        reset = 1;
        idle_inputs();
        model_reset();
        #2;
        chk("rst_rb", rb_coeffs, 64'h003D_0040_000D_0020);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err_zero_denom), 64'd0);
        chk("rst_upd", 64'(coeff_update), 64'd0);
        m_tready = 0;
        #1 chk("rst_s_tready_lo", 64'(s_tready), 64'd0);
        m_tready = 1;
        #1 chk("rst_s_tready_hi", 64'(s_tready), 64'd1);
        @(posedge clk);
        cyc++;
        #1 reset = 0;
    endtask

    initial begin
        int c0, seen;
        reset = 1;
        idle_inputs();
        model_reset();
        #12;
        do_reset();

        // Idle commit: exact four-cycle latency
        wr(8'd192, 32'd50); wr(8'd194, 32'd64); wr(8'd193, 32'd20); wr(8'd195, 32'd32);
        upd_cnt = 0; seen = -1;
        c0 = cyc;
        commit_req();
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (coeff_update === 1'b1 && seen < 0) seen = cyc;
        end
        chk("idle_latency", 64'(seen), 64'(c0 + 4));
        chk("idle_pulses", 64'(upd_cnt), 64'd1);
        chk("idle_rb", rb_coeffs, 64'h0032_0040_0014_0020);

        // Commit mid-packet: no swap before tlast
        wr(8'd192, 32'd33);
        upd_cnt = 0;
        send_pkt(16, 3, 1'b0);
        chk("midpkt_no_early_swap", 64'(upd_cnt), 64'd0);
        chk("midpkt_alpha_old", 64'(alpha_num), 64'd50);
        idle(10);
        chk("midpkt_pulses", 64'(upd_cnt), 64'd1);
        chk("midpkt_alpha_new", 64'(alpha_num), 64'd33);

        // Zero denominator rejected
        wr(8'd194, 32'd0);
        upd_cnt = 0;
        commit_req();
        idle(6);
        chk("zd_err", 64'(err_zero_denom), 64'd1);
        chk("zd_busy", 64'(busy), 64'd0);
        chk("zd_pulses", 64'(upd_cnt), 64'd0);
        chk("zd_rb", rb_coeffs, 64'h0021_0040_0014_0020);
        wr(8'd194, 32'd64);

        // Back-to-back commits: second one queued during the drain
        d_tready = 0;
        send_pkt(4, -1, 1'b0);
        upd_cnt = 0;
        commit_req();
        idle(3);
        wr(8'd192, 32'd7);
        commit_req();
        idle(3);
        d_tready = 1;
        idle(20);
        chk("b2b_pulses", 64'(upd_cnt), 64'd2);
        chk("b2b_alpha", 64'(alpha_num), 64'd7);

        // Output backpressure holds the drain
        d_tready = 0;
        send_pkt(5, -1, 1'b1);
        upd_cnt = 0;
        wr(8'd195, 32'd40);
        commit_req();
        idle(20);
        chk("bp_busy", 64'(busy), 64'd1);
        chk("bp_pulses", 64'(upd_cnt), 64'd0);
        chk("bp_hold", 64'(s_tready), 64'd0);
        d_tready = 1;
        idle(10);
        chk("bp_pulses_after", 64'(upd_cnt), 64'd1);
        chk("bp_beta_denom", 64'(beta_denom), 64'd40);

        // Spurious output beat at zero outstanding is ignored
        spur = 1; cycle(); spur = 0;
        idle(2);

        // In-flight counter saturation stalls input
        d_tready = 0;
        for (int i = 0; i < 270; i++) begin
            s_tvalid = 1;
            s_tlast  = (i % 16) == 15;
            cycle();
        end
        m_tready = 1;
        #1 chk("sat_hold", 64'(s_tready), 64'd0);
        s_tvalid = 0; s_tlast = 0;
        d_tready = 1;
        idle(300);
        send_pkt(1, -1, 1'b0);
        idle(5);

        // Async reset mid-drain
        d_tready = 0;
        send_pkt(5, -1, 1'b0);
        commit_req();
        idle(3);
        chk("pre_reset_busy", 64'(busy), 64'd1);
        do_reset();
        idle(3);

        // Random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            s_tvalid = ($urandom_range(0, 2) != 0);
            s_tlast  = ($urandom_range(0, 5) == 0);
            m_tready = ($urandom_range(0, 9) != 0);
            d_tready = ($urandom_range(0, 4) != 0);
            spur     = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 19) == 0) begin
                set_stb  = 1;
                set_addr = 8'(192 + $urandom_range(0, 4));
                set_data = ($urandom_range(0, 15) == 0) ? 32'd0 : 32'($urandom_range(1, 200));
            end
            cycle();
            set_stb = 0; set_addr = 8'd0; spur = 0;
        end
        idle_inputs();
        idle(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
